// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_dma
// Description : Block-transfer engine on the 8-bit data memory port.
//               A start pulse either copies len bytes from srcAddr to dstAddr
//               (read/write byte-serial, ascending) or fills len bytes at
//               dstAddr with fillValue. Addresses wrap modulo 2**ADDR_W.
// Ports       : clk, rst (async active-low)
//               start, fillMode, srcAddr, dstAddr, len, fillValue : request
//               memAddress, memWriteEn, memWriteData, memReadData : memory
//               busy (READ/WRITE), done (one-cycle completion pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fillMode,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fillValue,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memWriteEn,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_cur_src;
  logic [ADDR_W-1:0]   r_cur_dst;
  logic [ADDR_W-1:0]   r_remain;
  logic                r_fill_mode;
  logic [DATA_W-1:0]   r_fill_value;
  logic [DATA_W-1:0]   r_buf;

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0)    w_next_state = S_DONE;
          else if (fillMode) w_next_state = S_WRITE;
          else               w_next_state = S_READ;
        end
      end
      S_READ:  w_next_state = S_WRITE;
      S_WRITE: begin
        if (r_remain == c_ONE) w_next_state = S_DONE;
        else if (r_fill_mode)  w_next_state = S_WRITE;
        else                   w_next_state = S_READ;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cur_src    <= '0;
      r_cur_dst    <= '0;
      r_remain     <= '0;
      r_fill_mode  <= 1'b0;
      r_fill_value <= '0;
      r_buf        <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          // A zero-length request touches no registers; it only pulses done.
          if (start && (len != '0)) begin
            r_cur_src    <= srcAddr;
            r_cur_dst    <= dstAddr;
            r_remain     <= len;
            r_fill_mode  <= fillMode;
            r_fill_value <= fillValue;
          end
        end
        S_READ:  r_buf <= memReadData;
        S_WRITE: begin
          // Natural overflow gives the modulo-2**ADDR_W address wrap.
          r_cur_src <= r_cur_src + c_ONE;
          r_cur_dst <= r_cur_dst + c_ONE;
          r_remain  <= r_remain - c_ONE;
        end
        default: ;
      endcase
    end
  end

  // Outputs depend on state and registers only, never on the request inputs.
  always_comb begin
    memAddress   = '0;
    memWriteEn   = 1'b0;
    memWriteData = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_READ: begin
        memAddress = r_cur_src;
        busy       = 1'b1;
      end
      S_WRITE: begin
        memAddress   = r_cur_dst;
        memWriteEn   = 1'b1;
        memWriteData = r_fill_mode ? r_fill_value : r_buf;
        busy         = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_dma
// Description : Self-checking bench for mem_copy_dma. A behavioural memory
//               sits on the DUT memory port; a reference image of that memory
//               is updated byte by byte from the transfer rules and the
//               expected write stream and busy-cycle counts are queued for a
//               free-running monitor that compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_dma;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       fillMode = 1'b0;
  logic [7:0] srcAddr = '0;
  logic [7:0] dstAddr = '0;
  logic [7:0] len = '0;
  logic [7:0] fillValue = '0;
  logic [7:0] memAddress;
  logic       memWriteEn;
  logic [7:0] memWriteData;
  logic [7:0] memReadData;
  logic       busy;
  logic       done;

  mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .fillMode(fillMode),
    .srcAddr(srcAddr), .dstAddr(dstAddr), .len(len), .fillValue(fillValue),
    .memAddress(memAddress), .memWriteEn(memWriteEn),
    .memWriteData(memWriteData), .memReadData(memReadData),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with a bench-side preload port
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  assign memReadData = mem[memAddress];

  always @(posedge clk) begin
    if (pl_en)           mem[pl_addr] <= pl_data;
    else if (memWriteEn) mem[memAddress] <= memWriteData;
  end

  int errors = 0;
  int checks = 0;
  int exp_addr[$];
  int exp_data[$];
  int exp_busy[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (memWriteEn) begin
        chk("write_expected", int'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) begin
          chk("wr_addr", int'(memAddress), exp_addr.pop_front());
          chk("wr_data", int'(memWriteData), exp_data.pop_front());
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        chk("done_busy_low", int'(busy), 0);
        chk("done_expected", int'(exp_busy.size() > 0), 1);
        if (exp_busy.size() > 0) chk("busy_cycles", busy_cnt, exp_busy.pop_front());
        busy_cnt = 0;
      end
    end
  end

  task automatic preload(input int a, input int d);
    pl_en = 1'b1; pl_addr = 8'(a); pl_data = 8'(d);
    ref_mem[a % 256] = 8'(d);
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk(name, mism, 0);
  endtask

  // One transfer. abort_w>0 pulls reset during that write; poke_cyc>0 pulses a
  // spurious start with random arguments at that busy cycle.
  task automatic xfer(input bit fm, input int src, input int dst, input int ln,
                      input int fv, input int abort_w, input int poke_cyc);
    int nbytes, exp_lat, cyc, wcnt;
    bit seen;
    nbytes  = (abort_w > 0) ? abort_w - 1 : ln;
    exp_lat = (ln == 0) ? 0 : (fm ? ln : 2 * ln);
    for (int i = 0; i < nbytes; i++) begin
      int a, d;
      a = (dst + i) % 256;
      d = fm ? fv : int'(ref_mem[(src + i) % 256]);
      ref_mem[a] = 8'(d);
      exp_addr.push_back(a);
      exp_data.push_back(d);
    end
    if (abort_w == 0) exp_busy.push_back(exp_lat);

    @(posedge clk); #1;
    start = 1'b1; fillMode = fm; srcAddr = 8'(src); dstAddr = 8'(dst);
    len = 8'(ln); fillValue = 8'(fv);
    @(posedge clk); #1;
    // Inputs after the start cycle must not influence the transfer.
    start = 1'b0; srcAddr = 8'($urandom); dstAddr = 8'($urandom);
    len = 8'($urandom); fillValue = 8'($urandom); fillMode = 1'($urandom);
    cyc = 1; wcnt = 0; seen = 1'b0;
    while (!seen && cyc <= exp_lat + 8) begin
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", cyc, exp_lat + 1);
      end else begin
        if (memWriteEn) wcnt++;
        if (abort_w > 0 && wcnt == abort_w) begin
          rst = 1'b0;
          #1;
          chk("abort_busy", int'(busy), 0);
          chk("abort_we", int'(memWriteEn), 0);
          chk("abort_addr", int'(memAddress), 0);
          chk("abort_wdata", int'(memWriteData), 0);
          chk("abort_done", int'(done), 0);
          repeat (2) @(posedge clk);
          #1 rst = 1'b1;
          seen = 1'b1;
        end else begin
          if (cyc == poke_cyc) begin
            start = 1'b1; srcAddr = 8'($urandom); dstAddr = 8'($urandom);
            len = 8'($urandom_range(1, 255)); fillMode = 1'($urandom);
          end else begin
            start = 1'b0;
          end
          @(posedge clk); #1;
          cyc++;
        end
      end
    end
    start = 1'b0;
    chk("done_seen", int'(seen), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes", exp_addr.size(), 0);
    chk("pending_done", exp_busy.size(), 0);
    check_mem("mem_image");
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 256; i++) preload(i, int'($urandom_range(0, 255)));
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(memWriteEn), 0);
    chk("rst_addr", int'(memAddress), 0);
    chk("rst_wdata", int'(memWriteData), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Copy 5 bytes 101..105 -> 200..204
    for (int i = 0; i < 5; i++) preload(101 + i, i + 1);
    xfer(1'b0, 101, 200, 5, 0, 0, 0);
    // Fill 3 bytes at 50 with A5
    xfer(1'b1, 0, 50, 3, 8'hA5, 0, 0);
    // Zero length
    xfer(1'b0, 20, 30, 0, 0, 0, 0);
    xfer(1'b1, 20, 30, 0, 8'h3C, 0, 0);
    // Wrap on source
    preload(254, 7); preload(255, 8); preload(0, 9); preload(1, 10);
    xfer(1'b0, 254, 10, 4, 0, 0, 0);
    // Wrap on destination, fill mode
    xfer(1'b1, 0, 253, 6, 8'h5A, 0, 0);
    // Overlapping copy propagates the source pattern
    xfer(1'b0, 60, 61, 6, 0, 0, 0);
    // Reset during the 3rd write of a 5-byte copy, then a normal transfer
    xfer(1'b0, 120, 140, 5, 0, 3, 0);
    xfer(1'b0, 120, 140, 5, 0, 0, 0);
    // Start while busy is ignored
    xfer(1'b0, 30, 90, 5, 0, 0, 3);
    xfer(1'b1, 30, 90, 4, 8'h11, 0, 2);

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      int ln;
      ln = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      xfer(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           ln, int'($urandom_range(0, 255)), 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
